// File: rtl/cla_pkg.sv
// cla_pkg: shared width constant and nibble type for the 4-bit carry-lookahead slice
package cla_pkg;
  localparam int CLA_WIDTH = 4;
  typedef logic [CLA_WIDTH-1:0] nibble_t;
endpackage

// File: rtl/cla_pg_cell.sv
// cla_pg_cell: per-bit propagate/generate and sum bit (ports a, b, c in; p, g, s out)
module cla_pg_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic p,
  output logic g,
  output logic s
);
  assign p = a ^ b;
  assign g = a & b;
  assign s = p ^ c;
endmodule

// File: rtl/cla_adder4.sv
// cla_adder4: registered 4-bit lookahead adder (clk, rst, in_valid, a, b, cin in; s, cout, c3, out_valid out)
module cla_adder4
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             c3,
  output logic             out_valid
);
  nibble_t p, g, sum;
  logic [4:0] c;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    cla_pg_cell u_cell (.a(a[i]), .b(b[i]), .c(c[i]), .p(p[i]), .g(g[i]), .s(sum[i]));
  end
  // Carries use cin directly rather than c[0] so no carry bit depends on another bit of c.
  always_comb begin
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= '0;
      cout      <= 1'b0;
      c3        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= sum;
        cout <= c[4];
        c3   <= c[3];
      end
    end
  end
endmodule

// File: tb/tb_cla_adder4.sv
// tb_cla_adder4: scoreboard bench for cla_adder4
module tb_cla_adder4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic [3:0] s;
  logic       cout, c3, out_valid;
  int         checks = 0, errors = 0;
  logic [6:0] sb[$];
  logic [3:0] m_s = '0;
  logic       m_cout = 1'b0, m_c3 = 1'b0;

  cla_adder4 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .s(s), .cout(cout), .c3(c3), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {v,cout,c3,s}=%b expected %b", tag, act, exp);
    end
  endtask

  // Drive one cycle, push the model's expected output, then pop and compare after the edge.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [3:0] xa, input logic [3:0] xb, input logic xc);
    logic [4:0] full;
    logic [3:0] low;
    logic [6:0] exp;
    rst = r; in_valid = v; a = xa; b = xb; cin = xc;
    full = {1'b0, xa} + {1'b0, xb} + {4'b0, xc};
    low  = {1'b0, xa[2:0]} + {1'b0, xb[2:0]} + {3'b0, xc};
    if (r) begin
      m_s = '0; m_cout = 1'b0; m_c3 = 1'b0;
    end else if (v) begin
      m_s = full[3:0]; m_cout = full[4]; m_c3 = low[3];
    end
    sb.push_back({~r & v, m_cout, m_c3, m_s});
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    chk(tag, {out_valid, cout, c3, s}, exp);
  endtask

  initial begin
    step("reset_pri", 1, 1, 4'hF, 4'hF, 1);
    step("ovf_pos",   0, 1, 4'h7, 4'h1, 0);
    step("wrap_b1",   0, 1, 4'hF, 4'h1, 0);
    step("wrap_cin",  0, 1, 4'hF, 4'h0, 1);
    step("ovf_neg",   0, 1, 4'h8, 4'h8, 0);
    step("pipe_0",    0, 1, 4'h3, 4'h4, 0);
    step("pipe_1",    0, 1, 4'h5, 4'hA, 1);
    step("hold_0",    0, 0, 4'h2, 4'h2, 0);
    step("hold_1",    0, 0, 4'h9, 4'h6, 1);
    step("inflight",  0, 1, 4'hC, 4'h3, 1);
    step("mid_reset", 1, 0, 4'h0, 4'h0, 0);
    for (int i = 0; i < 512; i++) begin
      logic r, v;
      logic [8:0] k;
      k = i[8:0];
      r = ($urandom_range(0, 23) == 0);
      v = ($urandom_range(0, 9) != 0);
      if (r) step("rnd_rst", 1, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'($urandom));
      if (!v) step("rnd_idle", 0, 0, 4'($urandom), 4'($urandom), 1'($urandom));
      step("sweep", 0, 1, k[8:5], k[4:1], k[0]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
